// File: rtl/muldiv_seq_unit_if.sv
// ---------------------------------------------------------------------------
// muldiv_seq_unit_if
//   Request/response bundle between the EX stage and the sequential
//   multiply/divide unit.
//
//   Request side : valid_i, ready_o, op_i (funct3), val1_i (rs1), val2_i (rs2)
//   Control      : flush_i aborts whatever the unit is doing
//   Response side: valid_o, ready_i, result_o
//
//   master : the pipeline that issues requests and consumes results
//   slave  : the muldiv unit itself
// ---------------------------------------------------------------------------
interface muldiv_seq_unit_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic            ready_o;
    logic [2:0]      op_i;
    logic [XLEN-1:0] val1_i;
    logic [XLEN-1:0] val2_i;
    logic            flush_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] result_o;

    modport master (
        output valid_i, op_i, val1_i, val2_i, flush_i, ready_i,
        input  ready_o, valid_o, result_o
    );

    modport slave (
        input  valid_i, op_i, val1_i, val2_i, flush_i, ready_i,
        output ready_o, valid_o, result_o
    );
endinterface

// File: rtl/muldiv_seq_unit.sv
// ---------------------------------------------------------------------------
// muldiv_seq_unit
//   Multi-cycle RV32M-style multiply/divide unit living beside the ALU in EX.
//   Works on operand magnitudes: shift-add multiply and restoring divide,
//   retiring UNROLL bits per cycle, with the sign applied once at the end.
//   Divide-by-zero and signed divide overflow skip the iteration entirely.
//
// Ports
//   clk_i    : clock, rising edge
//   rst_n_i  : asynchronous active-low reset
//   bus      : muldiv_seq_unit_if.slave
//              valid_i/ready_o  request handshake (accepted only in IDLE)
//              op_i             0 MUL,1 MULH,2 MULHSU,3 MULHU,
//                               4 DIV,5 DIVU,6 REM,7 REMU
//              val1_i/val2_i    rs1 / rs2 operands
//              flush_i          abort, highest priority after reset
//              valid_o/ready_i  result handshake, result held until taken
//              result_o         result, stable while valid_o is high
// ---------------------------------------------------------------------------
module muldiv_seq_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    muldiv_seq_unit_if.slave    bus
);

    localparam int K     = XLEN / UNROLL;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

    // Architectural state
    logic [1:0]      state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]      op_q,     op_d;
    logic            neg_q,    neg_d;
    // acc: product high half (multiply) or partial remainder (divide)
    logic [XLEN:0]   acc_q,    acc_d;
    // shf: multiplier bits shifting out / dividend bits becoming quotient
    logic [XLEN-1:0] shf_q,    shf_d;
    // opnd: multiplicand (multiply) or divisor (divide) magnitude
    logic [XLEN-1:0] opnd_q,   opnd_d;
    logic [XLEN-1:0] result_q, result_d;

    // Request decode
    logic            in_s1_signed;
    logic            in_s2_signed;
    logic            in_neg1;
    logic            in_neg2;
    logic [XLEN-1:0] in_mag1;
    logic [XLEN-1:0] in_mag2;
    logic            in_neg_res;
    logic            in_div_zero;
    logic            in_div_ovf;
    logic            in_fast;
    logic [XLEN-1:0] in_fast_result;

    // Iteration and final correction
    logic [XLEN:0]     acc_n;
    logic [XLEN-1:0]   shf_n;
    logic [2*XLEN-1:0] prod_mag;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   calc_result;

    // Decode an incoming request into operand magnitudes and the sign of the
    // final result. The result sign is the product/quotient sign for most ops,
    // but REM takes the dividend sign. Unsigned operands never count as
    // negative, so MULHSU falls out of the same xor.
    always_comb begin
        in_s1_signed = (bus.op_i != 3'd3) && (bus.op_i != 3'd5) && (bus.op_i != 3'd7);
        in_s2_signed = in_s1_signed && (bus.op_i != 3'd2);
        in_neg1      = in_s1_signed && bus.val1_i[XLEN-1];
        in_neg2      = in_s2_signed && bus.val2_i[XLEN-1];
        in_mag1      = in_neg1 ? (~bus.val1_i + 1'b1) : bus.val1_i;
        in_mag2      = in_neg2 ? (~bus.val2_i + 1'b1) : bus.val2_i;
        in_neg_res   = (bus.op_i == 3'd6) ? in_neg1 : (in_neg1 ^ in_neg2);

        in_div_zero  = (bus.val2_i == '0);
        in_div_ovf   = ((bus.op_i == 3'd4) || (bus.op_i == 3'd6)) &&
                       (bus.val1_i == MOST_NEG) && (bus.val2_i == '1);
        in_fast      = bus.op_i[2] && (in_div_zero || in_div_ovf);

        // op_i[1] separates remainder ops from quotient ops
        if (in_div_zero) begin
            in_fast_result = bus.op_i[1] ? bus.val1_i : '1;
        end else begin
            in_fast_result = bus.op_i[1] ? '0 : bus.val1_i;
        end
    end

    // One CALC cycle worth of work: UNROLL radix-2 steps chained combinationally.
    // Multiply: add multiplicand when the multiplier lsb is set, then shift the
    // {acc,shf} pair right. Divide: shift the next dividend bit into the
    // partial remainder and subtract the divisor when it fits.
    always_comb begin
        acc_n = acc_q;
        shf_n = shf_q;
        for (int u = 0; u < UNROLL; u++) begin
            if (op_q[2]) begin
                acc_n = {acc_n[XLEN-1:0], shf_n[XLEN-1]};
                shf_n = {shf_n[XLEN-2:0], 1'b0};
                if (acc_n >= {1'b0, opnd_q}) begin
                    acc_n    = acc_n - {1'b0, opnd_q};
                    shf_n[0] = 1'b1;
                end
            end else begin
                if (shf_n[0]) begin
                    acc_n = acc_n + {1'b0, opnd_q};
                end
                shf_n = {acc_n[0], shf_n[XLEN-1:1]};
                acc_n = {1'b0, acc_n[XLEN:1]};
            end
        end
    end

    // Sign-correct the finished magnitude and pick the half/part the op wants.
    always_comb begin
        prod_mag = {acc_n[XLEN-1:0], shf_n};
        prod_fix = neg_q ? (~prod_mag + 1'b1) : prod_mag;
        quot_fix = neg_q ? (~shf_n + 1'b1) : shf_n;
        rem_fix  = neg_q ? (~acc_n[XLEN-1:0] + 1'b1) : acc_n[XLEN-1:0];

        if (op_q[2]) begin
            calc_result = op_q[1] ? rem_fix : quot_fix;
        end else if (op_q[1:0] == 2'd0) begin
            calc_result = prod_fix[XLEN-1:0];
        end else begin
            calc_result = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // Control: IDLE accepts, CALC iterates K times, DONE holds the result
    // until the consumer takes it. Flush beats everything and drops any
    // pending request or result.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        shf_d    = shf_q;
        opnd_d   = opnd_q;
        result_d = result_q;

        if (bus.flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.valid_i) begin
                        op_d  = bus.op_i;
                        neg_d = in_neg_res;
                        cnt_d = '0;
                        acc_d = '0;
                        if (bus.op_i[2]) begin
                            shf_d  = in_mag1;
                            opnd_d = in_mag2;
                        end else begin
                            shf_d  = in_mag2;
                            opnd_d = in_mag1;
                        end
                        if (in_fast) begin
                            result_d = in_fast_result;
                            state_d  = ST_DONE;
                        end else begin
                            state_d  = ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc_d = acc_n;
                    shf_d = shf_n;
                    if (cnt_q == CNT_LAST) begin
                        result_d = calc_result;
                        state_d  = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.ready_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            shf_q    <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            shf_q    <= shf_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
        end
    end

    assign bus.ready_o  = (state_q == ST_IDLE);
    assign bus.valid_o  = (state_q == ST_DONE);
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq_unit
//   Drives an UNROLL=1 and an UNROLL=4 instance with identical requests and
//   compares both against a plain-arithmetic RV32M reference model.
// ---------------------------------------------------------------------------
module tb_muldiv_seq_unit;

    localparam logic [31:0] MOST_NEG = 32'h8000_0000;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    muldiv_seq_unit_if #(.XLEN(32)) bus1 ();
    muldiv_seq_unit_if #(.XLEN(32)) bus4 ();

    muldiv_seq_unit #(.XLEN(32), .UNROLL(1)) dut1 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus1)
    );

    muldiv_seq_unit #(.XLEN(32), .UNROLL(4)) dut4 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus4)
    );

    // The second instance simply mirrors the request pins of the first
    assign bus4.valid_i = bus1.valid_i;
    assign bus4.op_i    = bus1.op_i;
    assign bus4.val1_i  = bus1.val1_i;
    assign bus4.val2_i  = bus1.val2_i;
    assign bus4.flush_i = bus1.flush_i;
    assign bus4.ready_i = bus1.ready_i;

    // Free-running 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV32M semantics straight from the ISA rules using 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          p;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * $signed(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                up = ua / ub;
                return up[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                up = ua % ub;
                return up[31:0];
            end
        endcase
    endfunction

    // Divide ops by zero or the one signed overflow case finish without iterating
    function automatic logic is_fast(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        return op[2] && ((b == 32'd0) ||
               (((op == 3'd4) || (op == 3'd6)) && (a == MOST_NEG) && (b == 32'hFFFF_FFFF)));
    endfunction

    // Single comparison point
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issue one request, scramble operands during the computation, measure
    // latency on both instances, hold the result for 'hold' cycles, then consume
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] expected,
                                 input int hold);
        int lat1;
        int lat4;
        int exp1;
        int exp4;
        exp1 = is_fast(op, a, b) ? 0 : 32;
        exp4 = is_fast(op, a, b) ? 0 : 8;

        @(negedge clk);
        bus1.valid_i = 1'b1;
        bus1.op_i    = op;
        bus1.val1_i  = a;
        bus1.val2_i  = b;
        @(posedge clk);
        #1;
        bus1.valid_i = 1'b0;
        bus1.val1_i  = $urandom;
        bus1.val2_i  = $urandom;
        bus1.op_i    = 3'($urandom_range(0, 7));

        lat1 = bus1.valid_o ? 0 : -1;
        lat4 = bus4.valid_o ? 0 : -1;
        for (int e = 1; e <= 60 && (lat1 < 0 || lat4 < 0); e++) begin
            @(posedge clk);
            #1;
            if (lat1 < 0 && bus1.valid_o) lat1 = e;
            if (lat4 < 0 && bus4.valid_o) lat4 = e;
        end
        checkOutput("latency_u1", 32'(lat1), 32'(exp1));
        checkOutput("latency_u4", 32'(lat4), 32'(exp4));
        checkOutput("result_u1", bus1.result_o, expected);
        checkOutput("result_u4", bus4.result_o, expected);

        repeat (hold) @(posedge clk);
        #1;
        checkOutput("hold_valid_u1", 32'(bus1.valid_o), 32'd1);
        checkOutput("hold_result_u1", bus1.result_o, expected);
        checkOutput("hold_result_u4", bus4.result_o, expected);

        @(negedge clk);
        bus1.ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus1.ready_i = 1'b0;
        checkOutput("consumed_valid_u1", 32'(bus1.valid_o), 32'd0);
        checkOutput("consumed_ready_u1", 32'(bus1.ready_o), 32'd1);
        checkOutput("consumed_ready_u4", 32'(bus4.ready_o), 32'd1);
    endtask

    // Watch for any spurious result over a window of cycles
    task automatic expectQuiet(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (bus1.valid_o || bus4.valid_o) seen = 1'b1;
        end
        checkOutput(tag, 32'(seen), 32'd0);
    endtask

    // Directed sequence followed by randomized traffic
    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          r;

        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus1.valid_i = 1'b0;
        bus1.op_i    = 3'd0;
        bus1.val1_i  = 32'd0;
        bus1.val2_i  = 32'd0;
        bus1.flush_i = 1'b0;
        bus1.ready_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", 32'(bus1.ready_o), 32'd1);
        checkOutput("reset_valid", 32'(bus1.valid_o), 32'd0);
        checkOutput("reset_result", bus1.result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed arithmetic");
        applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        applyStimulus(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1);
        applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0);
        applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        applyStimulus(3'd5, 32'd100, 32'd7, 32'd14, 0);
        applyStimulus(3'd7, 32'd100, 32'd7, 32'd2, 0);

        $display("[TB] fast path");
        applyStimulus(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        applyStimulus(3'd6, 32'd5, 32'd0, 32'd5, 0);
        applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

        $display("[TB] result held while consumer stalls");
        applyStimulus(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, ref_model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0), 10);

        $display("[TB] flush during CALC");
        @(negedge clk);
        bus1.valid_i = 1'b1;
        bus1.op_i    = 3'd5;
        bus1.val1_i  = 32'd1000;
        bus1.val2_i  = 32'd3;
        @(posedge clk);
        #1;
        bus1.valid_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus1.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus1.flush_i = 1'b0;
        checkOutput("flush_ready_u1", 32'(bus1.ready_o), 32'd1);
        checkOutput("flush_ready_u4", 32'(bus4.ready_o), 32'd1);
        checkOutput("flush_valid_u1", 32'(bus1.valid_o), 32'd0);
        expectQuiet("flush_no_result", 40);

        $display("[TB] flush blocks accept in IDLE");
        @(negedge clk);
        bus1.valid_i = 1'b1;
        bus1.flush_i = 1'b1;
        bus1.op_i    = 3'd0;
        bus1.val1_i  = 32'd3;
        bus1.val2_i  = 32'd4;
        @(posedge clk);
        #1;
        bus1.valid_i = 1'b0;
        bus1.flush_i = 1'b0;
        checkOutput("flush_accept_u1", 32'(bus1.ready_o), 32'd1);
        checkOutput("flush_accept_u4", 32'(bus4.ready_o), 32'd1);
        expectQuiet("flush_accept_quiet", 40);
        applyStimulus(3'd0, 32'd3, 32'd4, 32'd12, 0);

        $display("[TB] asynchronous reset mid-operation");
        applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        @(negedge clk);
        bus1.valid_i = 1'b1;
        bus1.op_i    = 3'd0;
        bus1.val1_i  = 32'd9;
        bus1.val2_i  = 32'd9;
        @(posedge clk);
        #1;
        bus1.valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ready", 32'(bus1.ready_o), 32'd1);
        checkOutput("async_rst_valid", 32'(bus1.valid_o), 32'd0);
        checkOutput("async_rst_result", bus1.result_o, 32'd0);
        checkOutput("async_rst_result_u4", bus4.result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expectQuiet("post_reset_quiet", 40);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            r  = int'($urandom_range(0, 9));
            if (r == 0) b = 32'd0;
            if (r == 1) begin
                a = MOST_NEG;
                b = 32'hFFFF_FFFF;
            end
            if (r == 2) b = 32'($urandom_range(1, 15));
            if (r == 3) a = -a;
            applyStimulus(op, a, b, ref_model(op, a, b), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
